wb_regfile_slave: RTL

Pipelined Wishbone B4 responder (slave) holding a small register bank: an ID word, a free-running cycle counter, and byte-writable scratch registers. It sits on the far side of the bus driven by the command-word Wishbone master and answers its single-beat reads and writes. The bus handshake is cycle-exact, with configurable wait states, `o_wb_stall` back-pressure, and `o_wb_err` for unmapped addresses.

---
 rtl/wb_regfile_slave.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_regfile_slave.sv
// Pipelined Wishbone B4 slave that serves an ID word, a free-running cycle counter and
// byte-writable scratch registers, with configurable wait states before each response.
module wb_regfile_slave #(
  parameter int          LGNREGS     = 4,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5742_0001
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data
);

  localparam int NREGS = 1 << LGNREGS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        commit_q, commit_d;
  logic        req_we_q, req_we_d;
  logic [29:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic [3:0]  req_sel_q, req_sel_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] scr_q [2:NREGS-1];
  logic [31:0] scr_d [2:NREGS-1];

  logic                accept;
  logic                mapped;
  logic [LGNREGS-1:0]  idx;
  logic [31:0]         rd_val;

  assign o_wb_stall = (state_q == S_WAIT);
  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_wb_data  = rdata_q;

  assign accept = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign mapped = (req_addr_q[29:LGNREGS] == '0);
  assign idx    = req_addr_q[LGNREGS-1:0];

  always_comb begin
    rd_val = 32'h0;
    if (idx == '0) begin
      rd_val = ID_VALUE;
    end else if (int'(idx) == 1) begin
      rd_val = cnt_q;
    end
    for (int i = 2; i < NREGS; i++) begin
      if (int'(idx) == i) rd_val = scr_q[i];
    end
  end

  // commit_q marks the cycle whose closing edge performs the write/read and raises ack/err;
  // dropping i_wb_cyc while anything is pending discards the request.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    commit_d   = 1'b0;
    req_we_d   = req_we_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_sel_d  = req_sel_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q + 32'd1;
    scr_d      = scr_q;

    if (commit_q && i_wb_cyc) begin
      if (!mapped) begin
        err_d   = 1'b1;
        rdata_d = 32'h0;
      end else if (req_we_q) begin
        ack_d   = 1'b1;
        rdata_d = 32'h0;
        for (int i = 2; i < NREGS; i++) begin
          if (int'(idx) == i) begin
            for (int b = 0; b < 4; b++) begin
              if (req_sel_q[b]) scr_d[i][8*b +: 8] = req_data_q[8*b +: 8];
            end
          end
        end
      end else begin
        ack_d   = 1'b1;
        rdata_d = rd_val;
      end
    end

    if (state_q == S_WAIT) begin
      if (!i_wb_cyc) begin
        state_d = S_IDLE;
      end else if (wcnt_q == 4'd0) begin
        state_d  = S_IDLE;
        commit_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q - 4'd1;
      end
    end

    if (accept) begin
      req_we_d   = i_wb_we;
      req_addr_d = i_wb_addr;
      req_data_d = i_wb_data;
      req_sel_d  = i_wb_sel;
      if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        wcnt_d  = WAIT_LOAD;
      end else begin
        commit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 4'd0;
      commit_q   <= 1'b0;
      req_we_q   <= 1'b0;
      req_addr_q <= 30'h0;
      req_data_q <= 32'h0;
      req_sel_q  <= 4'h0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      cnt_q      <= 32'h0;
      for (int i = 2; i < NREGS; i++) scr_q[i] <= 32'h0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      commit_q   <= commit_d;
      req_we_q   <= req_we_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_sel_q  <= req_sel_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      for (int i = 2; i < NREGS; i++) scr_q[i] <= scr_d[i];
    end
  end

endmodule
